// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Command-driven controller for one loadable up/down counter. Accepts a
//   count job over a valid/ready handshake, loads the start value, steps the
//   counter N times (optionally stopping at max/zero), then reports the final
//   count with a one-cycle done pulse.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready   job handshake
//   i_cmd_start           value loaded into the counter
//   i_cmd_up              1 = count up, 0 = count down
//   i_cmd_steps           number of count steps
//   i_cmd_sat             1 = stop at the boundary, 0 = wrap
//   o_cnt_*               drive the counter's rst_n/load_n/ce/up_down/data_load
//   i_cnt_*               counter's count_out/max_count/zero
//   o_busy, o_done        job in progress / one-cycle completion pulse
//   o_result_count/early  final count and early-stop flag of the last job
module counter_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [WIDTH-1:0] i_cmd_start,
   input  logic             i_cmd_up,
   input  logic [WIDTH-1:0] i_cmd_steps,
   input  logic             i_cmd_sat,
   output logic             o_cnt_rst_n,
   output logic             o_cnt_load_n,
   output logic             o_cnt_ce,
   output logic             o_cnt_up_down,
   output logic [WIDTH-1:0] o_cnt_data_load,
   input  logic [WIDTH-1:0] i_cnt_count_out,
   input  logic             i_cnt_max_count,
   input  logic             i_cnt_zero,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result_count,
   output logic             o_result_early
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_start;
   logic [WIDTH-1:0] r_remaining;
   logic [WIDTH-1:0] r_result_count;
   logic             r_up;
   logic             r_sat;
   logic             r_early;
   logic             r_result_early;
   logic             w_stop;

   // Boundary hit this RUN cycle, judged on the counter's registered outputs
   // so the step that would cross the boundary is never issued.
   assign w_stop = r_sat && (r_up ? i_cnt_max_count : i_cnt_zero);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= S_IDLE;
         r_remaining    <= '0;
         r_result_count <= '0;
         r_result_early <= 1'b0;
         r_early        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_cmd_valid) begin
                  r_start     <= i_cmd_start;
                  r_up        <= i_cmd_up;
                  r_sat       <= i_cmd_sat;
                  r_remaining <= i_cmd_steps;
                  r_early     <= 1'b0;
                  r_state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               // remaining still equals the requested step count here
               r_state <= (r_remaining == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
               if (w_stop) begin
                  r_early <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_remaining <= r_remaining - WIDTH'(1);
                  if (r_remaining == WIDTH'(1)) r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_result_count <= i_cnt_count_out;
               r_result_early <= r_early;
               r_state        <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Handshake/status outputs are forced low while reset is held, even though
   // the state register only updates at the next edge.
   assign o_cnt_rst_n     = ~i_rst;
   assign o_cmd_ready     = (r_state == S_IDLE) && !i_rst;
   assign o_busy          = (r_state != S_IDLE) && !i_rst;
   assign o_done          = (r_state == S_DONE) && !i_rst;

   assign o_cnt_load_n    = !(r_state == S_LOAD);
   assign o_cnt_data_load = (r_state == S_LOAD) ? r_start : '0;
   // Enable depends on the same-cycle boundary check, so it cannot be registered.
   assign o_cnt_ce        = (r_state == S_RUN) && !w_stop && !i_rst;
   assign o_cnt_up_down   = (r_state == S_RUN) ? r_up : 1'b0;

   // In DONE the live count is shown; it is captured at the end of the cycle.
   assign o_result_count  = (r_state == S_DONE) ? i_cnt_count_out : r_result_count;
   assign o_result_early  = (r_state == S_DONE) ? r_early : r_result_early;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [W-1:0] cmd_start = '0;
   logic         cmd_up = 1'b0;
   logic [W-1:0] cmd_steps = '0;
   logic         cmd_sat = 1'b0;
   logic         cnt_rst_n, cnt_load_n, cnt_ce, cnt_up_down;
   logic [W-1:0] cnt_data_load;
   logic [W-1:0] cnt_q;
   logic         cnt_max, cnt_zero;
   logic         busy, done;
   logic [W-1:0] result_count;
   logic         result_early;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] cnt;
      logic         early;
      int           cyc;
      int           ces;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   counter_sequencer #(.WIDTH(W)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_start(cmd_start), .i_cmd_up(cmd_up),
      .i_cmd_steps(cmd_steps), .i_cmd_sat(cmd_sat),
      .o_cnt_rst_n(cnt_rst_n), .o_cnt_load_n(cnt_load_n),
      .o_cnt_ce(cnt_ce), .o_cnt_up_down(cnt_up_down),
      .o_cnt_data_load(cnt_data_load),
      .i_cnt_count_out(cnt_q), .i_cnt_max_count(cnt_max), .i_cnt_zero(cnt_zero),
      .o_busy(busy), .o_done(done),
      .o_result_count(result_count), .o_result_early(result_early)
   );

   // Behavioural model of the external loadable up/down counter
   always @(posedge clk) begin
      if (!cnt_rst_n)      cnt_q <= '0;
      else if (!cnt_load_n) cnt_q <= cnt_data_load;
      else if (cnt_ce)      cnt_q <= cnt_up_down ? cnt_q + 1'b1 : cnt_q - 1'b1;
   end
   assign cnt_max  = (cnt_q == '1);
   assign cnt_zero = (cnt_q == '0);

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: counts cycles and ce pulses from the accepting edge and
   // scores every done pulse against the head of the expectation queue.
   int  m_cyc = 0;
   int  m_ces = 0;
   int  m_extra = 0;
   bit  m_in_job = 0;
   always @(negedge clk) begin
      if (rst) begin
         m_in_job = 0;
      end else begin
         if (m_in_job) begin
            m_cyc++;
            if (cnt_ce) m_ces++;
            if (cmd_ready && cmd_valid && busy) m_extra++;
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("result_count", int'(result_count), int'(e.cnt));
               check("result_early", int'(result_early), int'(e.early));
               check("done_cycle", m_cyc, e.cyc);
               check("ce_pulses", m_ces, e.ces);
               check("second_accept", m_extra, 0);
            end
            m_in_job = 0;
         end else if (cmd_valid && cmd_ready) begin
            m_in_job = 1;
            m_cyc = 0;
            m_ces = 0;
            m_extra = 0;
         end
      end
   end

   // Issue one job; if push is set the completion is expected and scored.
   task automatic run_job(input logic [W-1:0] st, input logic up, input logic [W-1:0] n,
                          input logic sat, input logic [W-1:0] ecnt, input logic eearly,
                          input int ecyc, input int eces, input bit hold);
      exp_t e;
      bit   fin;
      e.cnt = ecnt; e.early = eearly; e.cyc = ecyc; e.ces = eces;
      exp_q.push_back(e);
      cmd_start = st; cmd_up = up; cmd_steps = n; cmd_sat = sat;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      if (!hold) cmd_valid = 1'b0;
      fin = 0;
      for (int i = 0; i < 60 && !fin; i++) begin
         @(posedge clk); #1;
         if (cmd_ready && !busy) fin = 1;
      end
      cmd_valid = 1'b0;
      check("job_completes", int'(fin), 1);
      @(negedge clk);
      check("result_hold", int'(result_count), int'(ecnt));
      @(posedge clk); #1;
   endtask

   initial begin
      // Reset held for two cycles
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_cnt_rst_n", int'(cnt_rst_n), 0);
         check("rst_cmd_ready", int'(cmd_ready), 0);
         check("rst_done", int'(done), 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_result_count", int'(result_count), 0);
      check("post_rst_result_early", int'(result_early), 0);
      check("post_rst_cmd_ready", int'(cmd_ready), 1);
      @(posedge clk); #1;

      //      start up  n  sat  cnt  early cyc ce hold
      run_job(3,    1,  5, 0,   8,   0,    7,  5, 1);
      run_job(14,   1,  4, 0,   2,   0,    6,  4, 0);
      run_job(13,   1,  6, 1,   15,  1,    5,  2, 0);
      run_job(1,    0,  3, 1,   0,   1,    4,  1, 0);
      run_job(9,    0,  0, 0,   9,   0,    2,  0, 0);
      run_job(15,   1,  3, 1,   15,  1,    3,  0, 0);

      // Reset in cycle 5 of a long job: the job is abandoned
      cmd_start = 0; cmd_up = 1; cmd_steps = 10; cmd_sat = 0;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("midrst_cnt_rst_n", int'(cnt_rst_n), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_idle", int'(cmd_ready), 1);
      check("midrst_result_count", int'(result_count), 0);
      check("midrst_counter_cleared", int'(cnt_q), 0);
      check("midrst_no_pending", exp_q.size(), 0);
      @(posedge clk); #1;

      run_job(7,    0,  2, 0,   5,   0,    4,  2, 0);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Command-driven controller for the team's loadable up/down counter (`counter`, parameter `WIDTH`). It accepts count jobs over a valid/ready handshake and drives the counter's control pins to execute each job:
- load a start value;
- step N times in one direction, optionally stopping early at `max_count` or `zero`;
- report the final count with a one-cycle done pulse.

It sits between a job source (bench or higher-level FSM) and one `counter` instance, and owns all of that counter's inputs.

## Interface
- `WIDTH`, 4, width of counter value, start value and step count.

- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  job request.
- `cmd_ready`  out  1  controller can accept a job.
- `cmd_start`  in  WIDTH  value loaded into the counter.
- `cmd_up`  in  1  1 = count up, 0 = count down.
- `cmd_steps`  in  WIDTH  number of count steps, 0..2^WIDTH-1.
- `cmd_sat`  in  1  1 = stop at the boundary (max when up, zero when down); 0 = wrap modulo 2^WIDTH.
- `cnt_rst_n`  out  1  to the counter's `rst_n`.
- `cnt_load_n`  out  1  to the counter's `load_n`.
- `cnt_ce`  out  1  to the counter's `ce`.
- `cnt_up_down`  out  1  to the counter's `up_down`.
- `cnt_data_load`  out  WIDTH  to the counter's `data_load`.
- `cnt_count_out`  in  WIDTH  from the counter.
- `cnt_max_count`  in  1  from the counter.
- `cnt_zero`  in  1  from the counter.
- `busy`  out  1  a job is in progress (any state other than IDLE).
- `done`  out  1  one-cycle pulse: job complete.
- `result_count`  out  WIDTH  final count of the last job.
- `result_early`  out  1  last job stopped at the boundary before its N steps completed.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid && cmd_ready` at a posedge: capture start, direction, steps and sat; set `remaining`=steps; go to LOAD.
  - `cmd_valid` is ignored in every other state. The source holds the request until it is accepted.
- LOAD (exactly 1 cycle):
  - `cnt_load_n`=0, `cnt_data_load`=captured start, `cnt_ce`=0.
  - Next state is DONE if steps==0, otherwise RUN.
- RUN, each cycle:
  - Boundary check first. If sat=1 and ((up and `cnt_max_count`) or (down and `cnt_zero`)): `cnt_ce`=0, set the early flag, go to DONE. This check uses the counter's current registered outputs.
  - Otherwise: `cnt_ce`=1, `cnt_up_down`=direction, decrement `remaining`. If `remaining` was 1, go to DONE.
- DONE (exactly 1 cycle):
  - `done`=1.
  - `result_count` passes through `cnt_count_out`; `result_early` shows the early flag.
  - The result register captures both values at the end of the cycle. Next state is IDLE.
- Outside DONE, `result_count` and `result_early` hold the last captured values.
- Idle defaults: `cnt_load_n`=1, `cnt_ce`=0, `cnt_up_down`=0, `cnt_data_load`=0.
- `cnt_rst_n` = ~`rst` (combinational). The counter is held in reset whenever the controller is.
- Wrap-around with sat=0 is permitted and is modulo 2^WIDTH. `remaining` never wraps.
- Boundary with sat=1 and a start value already at the boundary: the first RUN cycle stops immediately with zero steps taken and `result_early`=1.

## Timing
- Reset:
  - `rst`=1 at a posedge forces IDLE and clears `remaining`, `result_count` and `result_early`.
  - While `rst` is high: `cmd_ready`=0, `busy`=0, `done`=0, `cnt_rst_n`=0.
  - Reset mid-job abandons the job: no `done`, and the counter is reset.
- Cycle 1 is the cycle after the accepting edge. The job runs LOAD in cycle 1, RUN in cycles 2..N+1, and DONE in cycle N+2.
- Without an early stop, `done` is high in cycle N+2. With an early stop after k steps, `done` is high in cycle k+3.
- `cmd_ready` rises in the cycle after DONE. The minimum spacing between accepts is N+3 cycles.
- Exactly N `cnt_ce` pulses are issued per non-early job. The counter is never enabled during LOAD or DONE.

## Test plan
- Reset: hold `rst` 2 cycles, then release. Required during reset: `cnt_rst_n`=0, `cmd_ready`=0, `done`=0. Required after release: `result_count`=0, `result_early`=0, `cmd_ready`=1 in the first cycle after release.
- Job start=3, up, steps=5, sat=0, with `cmd_valid` held high throughout. Required: `done` in cycle 7, `result_count`=8, `result_early`=0, exactly 5 `cnt_ce` pulses, and no second accept while `busy`.
- Wrap: start=14, up, steps=4, sat=0. Required: `result_count`=2, `result_early`=0, `done` in cycle 6.
- Saturate: start=13, up, steps=6, sat=1. Required: 2 `cnt_ce` pulses, `result_count`=15, `result_early`=1, `done` in cycle 5. Repeat down with start=1, steps=3. Required: `result_count`=0, `result_early`=1.
- Zero steps: start=9, down, steps=0. Required: LOAD then DONE, `done` in cycle 2, `result_count`=9, no `cnt_ce`.
- Reset mid-run: start=0, up, steps=10, with `rst` asserted in cycle 5. Required: next cycle IDLE, `cnt_rst_n`=0, no `done`, `result_count`=0. A fresh job after release completes normally.
